// File: rtl/posit_decode_pipe_pkg.sv
// Shared width helpers and the decoded-posit record for the posit datapath.
// posit_dec_t is sized for the default posit<32,2> configuration used downstream.
package posit_pkg;

   localparam int DEF_N  = 32;
   localparam int DEF_ES = 2;

   function automatic int rw_f(input int n);
      return $clog2(n);
   endfunction

   function automatic int sw_f(input int n, input int es);
      return $clog2(n) + es + 1;
   endfunction

   function automatic int fw_f(input int n, input int es);
      return n - 2 - es;
   endfunction

   typedef struct packed {
      logic                                   sign;
      logic                                   zero;
      logic                                   nar;
      logic signed [sw_f(DEF_N, DEF_ES)-1:0]  scale;
      logic        [fw_f(DEF_N, DEF_ES)-1:0]  frac;
   } posit_dec_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Input word handshake and decoded-result handshake of the posit decoder.
// The master side produces posit words and consumes results; the decoder is the slave.
interface posit_decode_pipe_if #(
   parameter int N  = 32,
   parameter int ES = 2
) ();
   import posit_pkg::*;

   logic                          in_valid;
   logic                          in_ready;
   logic [N-1:0]                  in_posit;
   logic                          out_valid;
   logic                          out_ready;
   logic                          out_sign;
   logic                          out_zero;
   logic                          out_nar;
   logic signed [sw_f(N, ES)-1:0] out_scale;
   logic [fw_f(N, ES)-1:0]        out_frac;

   modport master (
      output in_valid, in_posit, out_ready,
      input  in_ready, out_valid, out_sign, out_zero, out_nar, out_scale, out_frac
   );

   modport slave (
      input  in_valid, in_posit, out_ready,
      output in_ready, out_valid, out_sign, out_zero, out_nar, out_scale, out_frac
   );

endinterface

// File: rtl/posit_decode_pipe_count_regime.sv
// Counts how many leading bits of i_bits equal i_lead; the count saturates at W.
// Each position tests its whole prefix directly, so there is no ripple chain.
module count_regime #(
   parameter int W  = 31,
   parameter int CW = 5
) (
   input  logic [W-1:0]  i_bits,
   input  logic          i_lead,
   output logic [CW-1:0] o_run
);

   logic [W-1:0] w_same;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_prefix
         assign w_same[gi] = (i_bits[W-1:gi] == {(W-gi){i_lead}});
      end
   endgenerate

   always_comb begin
      o_run = '0;
      for (int i = 0; i < W; i++) begin
         o_run = o_run + CW'(w_same[i]);
      end
   end

endmodule

// File: rtl/posit_decode_pipe.sv
// Three-stage posit<N,ES> decoder: magnitude/specials, regime strip, scale/fraction assembly.
// All stages advance together unless the output register is full and not being drained.
module posit_decode_pipe
   import posit_pkg::*;
#(
   parameter int N  = 32,
   parameter int ES = 2
) (
   input logic                clk,
   input logic                rst,
   posit_decode_pipe_if.slave bus
);

   localparam int RW = rw_f(N);
   localparam int SW = sw_f(N, ES);
   localparam int FW = fw_f(N, ES);

   logic                 w_advance;

   logic                 w_sign;
   logic                 w_zero;
   logic                 w_nar;
   logic [N-2:0]         w_body;
   logic                 r_s1_valid;
   logic                 r_s1_sign;
   logic                 r_s1_zero;
   logic                 r_s1_nar;
   logic [N-2:0]         r_s1_body;

   logic                 w_r;
   logic [RW-1:0]        w_run;
   logic [RW-1:0]        w_shamt;
   logic signed [RW:0]   w_k;
   logic [N-4:0]         w_rest;
   logic                 r_s2_valid;
   logic                 r_s2_sign;
   logic                 r_s2_zero;
   logic                 r_s2_nar;
   logic signed [RW:0]   r_s2_k;
   logic [N-4:0]         r_s2_rest;

   logic signed [SW-1:0] w_scale;
   logic [FW-1:0]        w_frac;
   logic                 r_out_valid;
   logic                 r_out_sign;
   logic                 r_out_zero;
   logic                 r_out_nar;
   logic signed [SW-1:0] r_out_scale;
   logic [FW-1:0]        r_out_frac;

   assign w_advance    = !(r_out_valid && !bus.out_ready);
   assign bus.in_ready = w_advance;

   // Only the low N-1 bits of the magnitude are kept; the MSB is implied by the sign.
   assign w_sign = bus.in_posit[N-1];
   assign w_body = w_sign ? (~bus.in_posit[N-2:0] + {{(N-2){1'b0}}, 1'b1})
                          : bus.in_posit[N-2:0];
   assign w_zero = (bus.in_posit == '0);
   assign w_nar  = (bus.in_posit == {1'b1, {(N-1){1'b0}}});

   assign w_r = r_s1_body[N-2];

   count_regime #(
      .W  (N-1),
      .CW (RW)
   ) u_count_regime (
      .i_bits (r_s1_body),
      .i_lead (w_r),
      .o_run  (w_run)
   );

   // The run is always >= 1, so the regime MSB and terminator are dropped up front and
   // the remaining run-1 regime bits are shifted out; a saturated run leaves all zeros.
   assign w_shamt = w_run - {{(RW-1){1'b0}}, 1'b1};
   assign w_rest  = r_s1_body[N-4:0] << w_shamt;
   assign w_k     = w_r ? ($signed({1'b0, w_run}) - (RW+1)'(1))
                        : -$signed({1'b0, w_run});

   generate
      if (ES > 0) begin : g_exp
         logic [ES-1:0] w_e;
         assign w_e     = r_s2_rest[N-4 -: ES];
         assign w_scale = {r_s2_k, {ES{1'b0}}} + {{(SW-ES){1'b0}}, w_e};
         assign w_frac  = {1'b1, r_s2_rest[N-4-ES:0]};
      end else begin : g_noexp
         assign w_scale = r_s2_k;
         assign w_frac  = {1'b1, r_s2_rest};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s1_zero   <= 1'b0;
         r_s1_nar    <= 1'b0;
         r_s1_body   <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_sign   <= 1'b0;
         r_s2_zero   <= 1'b0;
         r_s2_nar    <= 1'b0;
         r_s2_k      <= '0;
         r_s2_rest   <= '0;
         r_out_valid <= 1'b0;
         r_out_sign  <= 1'b0;
         r_out_zero  <= 1'b0;
         r_out_nar   <= 1'b0;
         r_out_scale <= '0;
         r_out_frac  <= '0;
      end else if (w_advance) begin
         r_s1_valid  <= bus.in_valid;
         r_s1_sign   <= w_sign;
         r_s1_zero   <= w_zero;
         r_s1_nar    <= w_nar;
         r_s1_body   <= w_body;

         r_s2_valid  <= r_s1_valid;
         r_s2_sign   <= r_s1_sign;
         r_s2_zero   <= r_s1_zero;
         r_s2_nar    <= r_s1_nar;
         r_s2_k      <= w_k;
         r_s2_rest   <= w_rest;

         r_out_valid <= r_s2_valid;
         r_out_zero  <= r_s2_zero;
         r_out_nar   <= r_s2_nar;
         if (r_s2_zero || r_s2_nar) begin
            r_out_sign  <= 1'b0;
            r_out_scale <= '0;
            r_out_frac  <= '0;
         end else begin
            r_out_sign  <= r_s2_sign;
            r_out_scale <= w_scale;
            r_out_frac  <= w_frac;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_sign  = r_out_sign;
   assign bus.out_zero  = r_out_zero;
   assign bus.out_nar   = r_out_nar;
   assign bus.out_scale = r_out_scale;
   assign bus.out_frac  = r_out_frac;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe<32,2>: directed values, backpressure, mid-stream reset and
// random traffic, scored against a bit-queue posit decoder model.
module tb_posit_decode_pipe;
   import posit_pkg::*;

   localparam int N  = 32;
   localparam int ES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   posit_decode_pipe_if #(.N(N), .ES(ES)) bus ();

   posit_decode_pipe #(.N(N), .ES(ES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         delivered = 0;
   bit         lat_chk = 1'b0;
   bit         was_stalled = 1'b0;
   posit_dec_t held;
   posit_dec_t exp_q[$];
   int         acc_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Decode by walking the body bits as a list: regime run, terminator, exponent, fraction.
   function automatic posit_dec_t model(input logic [31:0] p);
      posit_dec_t d;
      bit         q[$];
      bit         r;
      logic [31:0] m;
      int         run;
      int         k;
      int         e;
      int         sc;
      d = '0;
      if (p == 32'h0) begin
         d.zero = 1'b1;
         return d;
      end
      if (p == 32'h8000_0000) begin
         d.nar = 1'b1;
         return d;
      end
      d.sign = p[31];
      m = p[31] ? -p : p;
      for (int i = 30; i >= 0; i--) q.push_back(m[i]);
      r = q[0];
      run = 0;
      while (q.size() > 0 && q[0] == r) begin
         void'(q.pop_front());
         run++;
      end
      if (q.size() > 0) void'(q.pop_front());
      k = r ? run - 1 : -run;
      e = 0;
      for (int i = 0; i < ES; i++) e = e * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
      sc = k * (1 << ES) + e;
      d.scale = 8'(sc);
      d.frac = 28'h800_0000;
      for (int i = 26; i >= 0; i--) d.frac[i] = (q.size() > 0) ? q.pop_front() : 1'b0;
      return d;
   endfunction

   function automatic posit_dec_t out_pack();
      posit_dec_t d;
      d.sign  = bus.out_sign;
      d.zero  = bus.out_zero;
      d.nar   = bus.out_nar;
      d.scale = bus.out_scale;
      d.frac  = bus.out_frac;
      return d;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      case ($urandom_range(0, 7))
         0:       w = 32'h0;
         1:       w = 32'h8000_0000;
         2:       w = 32'hFFFF_FFFF >> $urandom_range(0, 31);
         3:       w = 32'h1 << $urandom_range(0, 31);
         default: w = $urandom;
      endcase
      return w;
   endfunction

   // One cycle: drive at the falling edge, score the handshakes that the next rising edge takes.
   task automatic step(input logic v, input logic [31:0] w, input logic rdy, output bit acc);
      posit_dec_t cur;
      posit_dec_t want;
      int         acyc;
      bus.in_valid  = v;
      bus.in_posit  = w;
      bus.out_ready = rdy;
      #1;
      cur = out_pack();
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
         end else begin
            want = exp_q.pop_front();
            acyc = acc_q.pop_front();
            check_eq("result", 64'(cur), 64'(want));
            if (lat_chk) check_eq("latency", 64'(cyc - acyc), 64'd3);
            delivered++;
         end
      end
      if (bus.out_valid && !bus.out_ready) begin
         check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
         if (was_stalled) check_eq("stall_hold", 64'(cur), 64'(held));
         held = cur;
         was_stalled = 1'b1;
      end else begin
         check_eq("in_ready_open", 64'(bus.in_ready), 64'd1);
         was_stalled = 1'b0;
      end
      acc = v && bus.in_ready;
      if (acc) begin
         exp_q.push_back(model(w));
         acc_q.push_back(cyc);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      bit acc;
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 50) begin
         step(1'b0, 32'h0, 1'b1, acc);
         t++;
      end
      if (exp_q.size() > 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   logic [31:0] directed [8] = '{32'h4000_0000, 32'h4400_0000, 32'hC000_0000, 32'h4800_0000,
                                 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};

   initial begin
      bit          acc;
      int          idx;
      int          d0;
      bit          have;
      logic [31:0] cur_w;
      logic [31:0] bp_words [5];

      bus.in_valid  = 1'b0;
      bus.in_posit  = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("reset_valid", 64'(bus.out_valid), 64'd0);
      check_eq("reset_data", 64'(out_pack()), 64'd0);
      check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      lat_chk = 1'b1;
      foreach (directed[i]) step(1'b1, directed[i], 1'b1, acc);
      drain();

      lat_chk = 1'b0;
      for (int i = 0; i < 5; i++) bp_words[i] = rand_word();
      d0 = delivered;
      idx = 0;
      for (int t = 0; t < 20; t++) begin
         step(idx < 5, bp_words[idx % 5], !(t >= 3 && t < 7), acc);
         if (acc) idx++;
      end
      drain();
      check_eq("bp_delivered", 64'(delivered - d0), 64'd5);

      for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b1, acc);
      bus.in_valid = 1'b1;
      bus.in_posit = 32'h4800_0000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      acc_q.delete();
      was_stalled = 1'b0;
      #1;
      check_eq("midrst_valid", 64'(bus.out_valid), 64'd0);
      check_eq("midrst_data", 64'(out_pack()), 64'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 1'b1, acc);
         check_eq("midrst_no_stale", 64'(bus.out_valid), 64'd0);
      end
      lat_chk = 1'b1;
      step(1'b1, 32'h4000_0000, 1'b1, acc);
      drain();
      lat_chk = 1'b0;

      have  = 1'b0;
      cur_w = '0;
      for (int t = 0; t < 400; t++) begin
         if (!have) begin
            cur_w = rand_word();
            have  = ($urandom_range(0, 3) != 0);
         end
         step(have, cur_w, $urandom_range(0, 9) < 7, acc);
         if (acc) have = 1'b0;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Three-stage pipelined posit decoder that unpacks an N-bit posit<N,ES> into sign, signed scale and normalised fraction for the arithmetic datapath.
- Sits directly downstream of the regime run-length counter, which it instantiates in stage 2, and feeds the add/mul units.
- Valid/ready handshake on input and output, with full backpressure.

Parameters:
- N, 32, posit word width; legal range 8..32.
- ES, 2, exponent field width; legal range 0..3.
- Derived: RW = $clog2(N) (run-length width); SW = RW+ES+1 (signed scale width); FW = N-2-ES (fraction output width including hidden bit).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage 1 can accept a word this cycle.
- in_posit  in  N  raw posit word.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sign  out  1  sign of the value.
- out_zero  out  1  input was 0.
- out_nar  out  1  input was NaR (1 followed by N-1 zeros).
- out_scale  out  SW  signed scale, k*2^ES + e.
- out_frac  out  FW  fraction with hidden 1 at MSB, left-aligned, zero-padded.

Behaviour:
- Reset: one cycle of rst clears all stage valid bits. After reset, out_valid=0, out_sign=0, out_zero=0, out_nar=0, out_scale=0, out_frac=0. Data registers are also cleared.
- Stall rule: advance = !(out_valid && !out_ready). in_ready = advance, combinational. When advance=1, all three stages shift together. When advance=0, all stages hold.
- Bubbles are not collapsed. Fixed latency is 3 cycles from the accepting edge to out_valid when there is no backpressure. Throughput is 1 word per cycle.
- Stage 1:
  - Capture sign = in_posit[N-1].
  - Set mag = two's complement of in_posit if sign=1, else in_posit.
  - Detect zero (all bits 0) and NaR (10...0) on the raw word.
  - Register body = mag[N-2:0] and the flags.
- Stage 2:
  - Regime bit r = body[N-2].
  - run = count of leading bits equal to r, via count_regime (width N-1); run is saturated at N-1.
  - k = run-1 if r=1; k = -run if r=0.
  - Shift body left by run+1 to strip the regime and its terminator. If run = N-1 there is no terminator and the shifted result is all zeros.
- Stage 3:
  - e = top ES bits of the shifted body. Bits beyond the word end read as 0.
  - Fraction bits are the next FW-1 bits.
  - out_scale = (k <<< ES) + e.
  - out_frac = {1'b1, fraction}.
- Special cases:
  - zero → out_zero=1, sign=0, scale=0, frac=0.
  - NaR → out_nar=1, sign=0, scale=0, frac=0.
  - zero and NaR are mutually exclusive.
- Output registers hold their value while out_valid && !out_ready. The result is consumed on any edge where out_valid && out_ready.
- Reset asserted mid-stream discards every in-flight word. No output handshake occurs on that edge or after it until new input is accepted.
- in_valid=0 with advance=1 inserts a bubble: that stage's valid=0, and its data value is don't-care.

Decomposition:
- Package posit_pkg:
  - Derived constant functions for RW, SW and FW.
  - Typedef posit_dec_t {sign, zero, nar, scale, frac}, used for out_* and for downstream ports.
- One sub-module: the existing count_regime, instantiated in stage 2 with width N-1. Its leading-bit selection is driven by the runtime r.
- Everything else is inline.

Test Plan:
(N=32, ES=2; output is 28'h frac.)
- 1.0 and 1.5: in 0x40000000 → 3 cycles later sign=0, scale=0, frac=28'h8000000. In 0x44000000 → scale=0, frac=28'hC000000.
- Negative and exponent: in 0xC0000000 → sign=1, scale=0, frac=28'h8000000. In 0x48000000 → sign=0, scale=1, frac=28'h8000000.
- Extremes: in 0x7FFFFFFF → scale=120, frac=28'h8000000. In 0x00000001 → scale=-120, frac=28'h8000000.
- Specials: in 0x00000000 → zero=1, nar=0, scale=0, frac=0. In 0x80000000 → nar=1, zero=0.
- Backpressure: stream 5 words back-to-back and hold out_ready=0 for 4 cycles after the first out_valid.
  - Required: in_ready=0 during the stall and out_* stable.
  - Required: all 5 results delivered in order, none lost or duplicated.
- Reset mid-operation: accept 3 words, assert rst for 1 cycle at cycle 2.
  - Required: out_valid=0 and all outputs 0 the cycle after reset, and no stale result ever appears.
  - Then feed 0x40000000 → correct result 3 cycles later.
